// File: rtl/sfm_slot_cache.sv
// sfm_slot_cache: fully-associative cache of softmax state slots (max, den)
// backed by a memory-resident slot table of 64-bit records.
//
// Ports:
//   clk_i, rst_i (sync, active-high), clear_i (sync flush)
//   cache_base_addr_i        : byte base address of the slot table
//   req_*                    : ALLOC(0)/LOAD(1) slot requests
//   upd_*                    : UPDATE(0)/FREE(1) slot commands
//   rd_addr_i, slot_*_o      : combinational lookup of the current slot
//   mem_*                    : single-outstanding TCDM port (wen=1 read)
//
// Config macro: SFM_SLOT_CACHE_WRITEBACK_EN
//   defined   -> write-back (dirty bits, evictions)
//   undefined -> write-through (every UPDATE writes memory)

module sfm_slot_cache #(
  parameter int unsigned N_ENTRIES = 4,
  parameter int unsigned MAX_WIDTH = 16,
  parameter int unsigned DEN_WIDTH = 32,
  parameter logic [MAX_WIDTH-1:0] MAX_INIT = 16'hFF80
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic [31:0]          cache_base_addr_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [15:0]          req_addr_i,
  input  logic                 req_op_i,
  input  logic                 upd_valid_i,
  output logic                 upd_ready_o,
  input  logic [15:0]          upd_addr_i,
  input  logic                 upd_op_i,
  input  logic [MAX_WIDTH-1:0] upd_max_i,
  input  logic [DEN_WIDTH-1:0] upd_den_i,
  input  logic [15:0]          rd_addr_i,
  output logic                 slot_valid_o,
  output logic [MAX_WIDTH-1:0] slot_max_o,
  output logic [DEN_WIDTH-1:0] slot_den_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_wen_o,
  output logic [31:0]          mem_add_o,
  output logic [63:0]          mem_data_o,
  input  logic [63:0]          mem_r_data_i,
  input  logic                 mem_r_valid_i
);

  localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE, EVICT, FETCH_REQ, FETCH_WAIT
  } state_t;

  state_t               state_q;
  logic [N_ENTRIES-1:0] valid_q;
  logic [15:0]          tag_q [N_ENTRIES];
  logic [MAX_WIDTH-1:0] max_q [N_ENTRIES];
  logic [DEN_WIDTH-1:0] den_q [N_ENTRIES];
  logic [IW-1:0]        rr_q;
  logic [IW-1:0]        vic_q;
  logic [15:0]          fl_tag_q;
  logic                 fl_op_q;
  logic                 wr_busy_q;

  logic          rd_hit, req_hit_raw, upd_hit;
  logic [IW-1:0] rd_idx, req_idx, upd_idx;

  always_comb begin
    rd_hit      = 1'b0;
    req_hit_raw = 1'b0;
    upd_hit     = 1'b0;
    rd_idx      = '0;
    req_idx     = '0;
    upd_idx     = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == rd_addr_i) begin
        rd_hit = 1'b1;
        rd_idx = IW'(i);
      end
      if (valid_q[i] && tag_q[i] == req_addr_i) begin
        req_hit_raw = 1'b1;
        req_idx     = IW'(i);
      end
      if (valid_q[i] && tag_q[i] == upd_addr_i) begin
        upd_hit = 1'b1;
        upd_idx = IW'(i);
      end
    end
  end

  assign slot_valid_o = rd_hit;
  assign slot_max_o   = rd_hit ? max_q[rd_idx] : '0;
  assign slot_den_o   = rd_hit ? den_q[rd_idx] : '0;

  logic is_idle, gnt, upd_is_upd, upd_memwr;
  logic upd_blk, upd_wait, upd_fire;
  logic upd_set, upd_free, upd_wr_start;

  assign is_idle    = (state_q == IDLE);
  assign gnt        = mem_gnt_i && mem_req_o;
  assign upd_is_upd = (upd_op_i == 1'b0);

`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
  assign upd_memwr = upd_is_upd && !upd_hit;
`else
  assign upd_memwr = upd_is_upd;
`endif

  // Block updates racing with the slot being fetched or evicted.
  assign upd_blk = !is_idle && (upd_addr_i == fl_tag_q ||
    (state_q == EVICT && upd_addr_i == tag_q[vic_q]));

  always_comb begin
    upd_wait = 1'b0;
    if (!is_idle)
      upd_wait = upd_blk || !upd_hit || upd_memwr;
    else
      upd_wait = upd_memwr && !(wr_busy_q && gnt);
  end

  assign upd_ready_o  = !(upd_valid_i && upd_wait);
  assign upd_fire     = upd_valid_i && upd_ready_o;
  assign upd_set      = upd_fire && upd_hit && upd_is_upd;
  assign upd_free     = upd_fire && upd_hit && !upd_is_upd;
  assign upd_wr_start = is_idle && upd_valid_i && upd_memwr &&
                        !wr_busy_q;

  // Request sees the effect of a same-cycle update.
  logic                 req_hit, req_fire;
  logic [N_ENTRIES-1:0] valid_eff;
  logic                 vic_free, vic_dirty, vic_upd;
  logic [IW-1:0]        vic_idx;
  logic [MAX_WIDTH-1:0] vic_max;
  logic [DEN_WIDTH-1:0] vic_den;

  assign req_hit = req_hit_raw &&
                   !(upd_free && upd_idx == req_idx);

  always_comb begin
    valid_eff = valid_q;
    if (upd_free) valid_eff[upd_idx] = 1'b0;
  end

  always_comb begin
    vic_free = 1'b0;
    vic_idx  = rr_q;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_eff[i]) begin
        vic_free = 1'b1;
        vic_idx  = IW'(i);
      end
    end
  end

  assign vic_upd = upd_set && upd_idx == vic_idx;
  assign vic_max = vic_upd ? upd_max_i : max_q[vic_idx];
  assign vic_den = vic_upd ? upd_den_i : den_q[vic_idx];

`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
  logic [N_ENTRIES-1:0] dirty_q;
  assign vic_dirty = valid_eff[vic_idx] &&
                     (dirty_q[vic_idx] || vic_upd);
`else
  assign vic_dirty = 1'b0;
`endif

  assign req_ready_o = is_idle && !(req_valid_i && !req_hit &&
                       (wr_busy_q || upd_wr_start));
  assign req_fire    = req_valid_i && req_ready_o;

  function automatic logic [31:0] rec_addr(input logic [15:0] s);
    return cache_base_addr_i + {13'd0, s, 3'd0};
  endfunction

  function automatic logic [63:0] mk_rec(
    input logic [MAX_WIDTH-1:0] m,
    input logic [DEN_WIDTH-1:0] d
  );
    logic [63:0] r;
    r                = '0;
    r[DEN_WIDTH-1:0] = d;
    r[32+:MAX_WIDTH] = m;
    return r;
  endfunction

  logic unused_rdata;
  assign unused_rdata = ^mem_r_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      rr_q       <= '0;
      vic_q      <= '0;
      fl_tag_q   <= '0;
      fl_op_q    <= 1'b0;
      wr_busy_q  <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_wen_o  <= 1'b1;
      mem_add_o  <= '0;
      mem_data_o <= '0;
`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
      dirty_q    <= '0;
`endif
    end else begin
      // Updates first; request writes below override on conflict.
      if (upd_set) begin
        max_q[upd_idx] <= upd_max_i;
        den_q[upd_idx] <= upd_den_i;
`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
        dirty_q[upd_idx] <= 1'b1;
`endif
      end
      if (upd_free) begin
        valid_q[upd_idx] <= 1'b0;
`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
        dirty_q[upd_idx] <= 1'b0;
`endif
      end

      if (upd_wr_start) begin
        wr_busy_q  <= 1'b1;
        mem_req_o  <= 1'b1;
        mem_wen_o  <= 1'b0;
        mem_add_o  <= rec_addr(upd_addr_i);
        mem_data_o <= mk_rec(upd_max_i, upd_den_i);
      end else if (wr_busy_q && gnt) begin
        wr_busy_q <= 1'b0;
        mem_req_o <= 1'b0;
        mem_wen_o <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (req_fire && req_hit) begin
            if (req_op_i == 1'b0) begin
              max_q[req_idx] <= MAX_INIT;
              den_q[req_idx] <= '0;
`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
              dirty_q[req_idx] <= 1'b0;
`endif
            end
          end else if (req_fire) begin
            vic_q    <= vic_idx;
            fl_tag_q <= req_addr_i;
            fl_op_q  <= req_op_i;
            if (!vic_free)
              rr_q <= (rr_q == IW'(N_ENTRIES - 1)) ? '0 : rr_q + 1'b1;
            if (vic_dirty) begin
              state_q    <= EVICT;
              mem_req_o  <= 1'b1;
              mem_wen_o  <= 1'b0;
              mem_add_o  <= rec_addr(tag_q[vic_idx]);
              mem_data_o <= mk_rec(vic_max, vic_den);
            end else if (req_op_i == 1'b0) begin
              valid_q[vic_idx] <= 1'b1;
              tag_q[vic_idx]   <= req_addr_i;
              max_q[vic_idx]   <= MAX_INIT;
              den_q[vic_idx]   <= '0;
            end else begin
              valid_q[vic_idx] <= 1'b0;
              state_q          <= FETCH_REQ;
              mem_req_o        <= 1'b1;
              mem_wen_o        <= 1'b1;
              mem_add_o        <= rec_addr(req_addr_i);
              mem_data_o       <= '0;
            end
          end
        end
        EVICT: begin
          if (gnt) begin
            valid_q[vic_q] <= 1'b0;
`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
            dirty_q[vic_q] <= 1'b0;
`endif
            if (fl_op_q == 1'b0) begin
              valid_q[vic_q] <= 1'b1;
              tag_q[vic_q]   <= fl_tag_q;
              max_q[vic_q]   <= MAX_INIT;
              den_q[vic_q]   <= '0;
              state_q        <= IDLE;
              mem_req_o      <= 1'b0;
              mem_wen_o      <= 1'b1;
            end else begin
              state_q    <= FETCH_REQ;
              mem_wen_o  <= 1'b1;
              mem_add_o  <= rec_addr(fl_tag_q);
              mem_data_o <= '0;
            end
          end
        end
        FETCH_REQ: begin
          if (gnt) begin
            state_q   <= FETCH_WAIT;
            mem_req_o <= 1'b0;
          end
        end
        FETCH_WAIT: begin
          if (mem_r_valid_i) begin
            valid_q[vic_q] <= 1'b1;
            tag_q[vic_q]   <= fl_tag_q;
            max_q[vic_q]   <= mem_r_data_i[32+:MAX_WIDTH];
            den_q[vic_q]   <= mem_r_data_i[DEN_WIDTH-1:0];
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfm_slot_cache.sv
// tb_sfm_slot_cache: directed self-checking bench for sfm_slot_cache.
// Runs in either configuration of SFM_SLOT_CACHE_WRITEBACK_EN.

module tb_sfm_slot_cache;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i;
  logic [31:0] cache_base_addr_i;
  logic        req_valid_i, req_ready_o, req_op_i;
  logic [15:0] req_addr_i;
  logic        upd_valid_i, upd_ready_o, upd_op_i;
  logic [15:0] upd_addr_i;
  logic [15:0] upd_max_i;
  logic [31:0] upd_den_i;
  logic [15:0] rd_addr_i;
  logic        slot_valid_o;
  logic [15:0] slot_max_o;
  logic [31:0] slot_den_o;
  logic        mem_req_o, mem_gnt_i, mem_wen_o;
  logic [31:0] mem_add_o;
  logic [63:0] mem_data_o, mem_r_data_i;
  logic        mem_r_valid_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  sfm_slot_cache dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .cache_base_addr_i(cache_base_addr_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_op_i(req_op_i),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_addr_i(upd_addr_i), .upd_op_i(upd_op_i),
    .upd_max_i(upd_max_i), .upd_den_i(upd_den_i),
    .rd_addr_i(rd_addr_i), .slot_valid_o(slot_valid_o),
    .slot_max_o(slot_max_o), .slot_den_o(slot_den_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_wen_o(mem_wen_o), .mem_add_o(mem_add_o),
    .mem_data_o(mem_data_o), .mem_r_data_i(mem_r_data_i),
    .mem_r_valid_i(mem_r_valid_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1; clear_i = 0; cache_base_addr_i = 32'h1000;
    req_valid_i = 0; req_addr_i = 0; req_op_i = 0;
    upd_valid_i = 0; upd_addr_i = 0; upd_op_i = 0;
    upd_max_i = 0; upd_den_i = 0; rd_addr_i = 0;
    mem_gnt_i = 0; mem_r_data_i = 0; mem_r_valid_i = 0;
    tick(); tick();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%h exp=1", req_ready_o); end
    total++; if (upd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_upd_ready got=%h exp=1", upd_ready_o); end
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL rst_slot_valid got=%h exp=0", slot_valid_o); end
    total++; if (slot_max_o !== 16'h0) begin bad++; $display("FAIL rst_slot_max got=%h exp=0", slot_max_o); end
    total++; if (slot_den_o !== 32'h0) begin bad++; $display("FAIL rst_slot_den got=%h exp=0", slot_den_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%h exp=0", mem_req_o); end
    total++; if (mem_wen_o !== 1'b1) begin bad++; $display("FAIL rst_mem_wen got=%h exp=1", mem_wen_o); end
    total++; if (mem_add_o !== 32'h0) begin bad++; $display("FAIL rst_mem_add got=%h exp=0", mem_add_o); end
    total++; if (mem_data_o !== 64'h0) begin bad++; $display("FAIL rst_mem_data got=%h exp=0", mem_data_o); end
    rst_i = 0;
    tick();
  endtask

  task automatic test_load_miss();
    rd_addr_i = 3;
    req_valid_i = 1; req_addr_i = 3; req_op_i = 1;
    #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL load_ready got=%h exp=1", req_ready_o); end
    tick();
    req_valid_i = 0;
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL load_req got=%h exp=1", mem_req_o); end
    total++; if (mem_wen_o !== 1'b1) begin bad++; $display("FAIL load_wen got=%h exp=1", mem_wen_o); end
    total++; if (mem_add_o !== 32'h1018) begin bad++; $display("FAIL load_addr got=%h exp=1018", mem_add_o); end
    tick(); tick();
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL load_req_hold got=%h exp=1", mem_req_o); end
    total++; if (mem_add_o !== 32'h1018) begin bad++; $display("FAIL load_addr_hold got=%h exp=1018", mem_add_o); end
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%h exp=0", mem_req_o); end
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL load_early_valid got=%h exp=0", slot_valid_o); end
    tick();
    mem_r_valid_i = 1; mem_r_data_i = 64'h0000_4000_3F80_0000;
    #1;
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL load_bypass got=%h exp=0", slot_valid_o); end
    tick();
    mem_r_valid_i = 0;
    total++; if (slot_valid_o !== 1'b1) begin bad++; $display("FAIL load_valid got=%h exp=1", slot_valid_o); end
    total++; if (slot_max_o !== 16'h4000) begin bad++; $display("FAIL load_max got=%h exp=4000", slot_max_o); end
    total++; if (slot_den_o !== 32'h3F80_0000) begin bad++; $display("FAIL load_den got=%h exp=3f800000", slot_den_o); end
  endtask

  task automatic test_alloc();
    rd_addr_i = 7;
    req_valid_i = 1; req_addr_i = 7; req_op_i = 0;
    #1;
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL alloc_pre_valid got=%h exp=0", slot_valid_o); end
    tick();
    req_valid_i = 0;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL alloc_mem got=%h exp=0", mem_req_o); end
    total++; if (slot_valid_o !== 1'b1) begin bad++; $display("FAIL alloc_valid got=%h exp=1", slot_valid_o); end
    total++; if (slot_max_o !== 16'hFF80) begin bad++; $display("FAIL alloc_max got=%h exp=ff80", slot_max_o); end
    total++; if (slot_den_o !== 32'h0) begin bad++; $display("FAIL alloc_den got=%h exp=0", slot_den_o); end
  endtask

  task automatic test_same_cycle();
    req_valid_i = 1; req_addr_i = 2; req_op_i = 0;
    tick();
    rd_addr_i = 2;
    upd_valid_i = 1; upd_addr_i = 2; upd_op_i = 0;
    upd_max_i = 16'h4100; upd_den_i = 32'h1234;
    req_addr_i = 2; req_op_i = 1;
    #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL same_req_ready got=%h exp=1", req_ready_o); end
`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
    total++; if (upd_ready_o !== 1'b1) begin bad++; $display("FAIL same_upd_ready got=%h exp=1", upd_ready_o); end
    tick();
    req_valid_i = 0; upd_valid_i = 0;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL same_mem got=%h exp=0", mem_req_o); end
`else
    total++; if (upd_ready_o !== 1'b0) begin bad++; $display("FAIL same_upd_wait got=%h exp=0", upd_ready_o); end
    tick();
    req_valid_i = 0;
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL same_wr_req got=%h exp=1", mem_req_o); end
    total++; if (mem_wen_o !== 1'b0) begin bad++; $display("FAIL same_wr_wen got=%h exp=0", mem_wen_o); end
    total++; if (mem_add_o !== 32'h1010) begin bad++; $display("FAIL same_wr_addr got=%h exp=1010", mem_add_o); end
    total++; if (mem_data_o !== 64'h0000_4100_0000_1234) begin bad++; $display("FAIL same_wr_data got=%h exp=0000410000001234", mem_data_o); end
    total++; if (slot_max_o !== 16'hFF80) begin bad++; $display("FAIL same_early_max got=%h exp=ff80", slot_max_o); end
    mem_gnt_i = 1;
    #1;
    total++; if (upd_ready_o !== 1'b1) begin bad++; $display("FAIL same_gnt_ready got=%h exp=1", upd_ready_o); end
    tick();
    mem_gnt_i = 0; upd_valid_i = 0;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL same_wr_done got=%h exp=0", mem_req_o); end
`endif
    total++; if (slot_max_o !== 16'h4100) begin bad++; $display("FAIL same_max got=%h exp=4100", slot_max_o); end
    total++; if (slot_den_o !== 32'h1234) begin bad++; $display("FAIL same_den got=%h exp=1234", slot_den_o); end
  endtask

  task automatic test_writethrough();
    req_valid_i = 1; req_addr_i = 1; req_op_i = 0;
    tick();
    req_valid_i = 0;
    rd_addr_i = 1;
    upd_valid_i = 1; upd_addr_i = 1; upd_op_i = 0;
    upd_max_i = 16'h3C00; upd_den_i = 32'hAAAA_5555;
    #1;
`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
    total++; if (upd_ready_o !== 1'b1) begin bad++; $display("FAIL wb_upd_ready got=%h exp=1", upd_ready_o); end
    tick();
    upd_valid_i = 0;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL wb_upd_mem got=%h exp=0", mem_req_o); end
`else
    total++; if (upd_ready_o !== 1'b0) begin bad++; $display("FAIL wt_ready0 got=%h exp=0", upd_ready_o); end
    tick();
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL wt_req got=%h exp=1", mem_req_o); end
    total++; if (mem_wen_o !== 1'b0) begin bad++; $display("FAIL wt_wen got=%h exp=0", mem_wen_o); end
    total++; if (mem_add_o !== 32'h1008) begin bad++; $display("FAIL wt_addr got=%h exp=1008", mem_add_o); end
    total++; if (mem_data_o !== 64'h0000_3C00_AAAA_5555) begin bad++; $display("FAIL wt_data got=%h exp=00003c00aaaa5555", mem_data_o); end
    total++; if (upd_ready_o !== 1'b0) begin bad++; $display("FAIL wt_ready1 got=%h exp=0", upd_ready_o); end
    tick();
    total++; if (upd_ready_o !== 1'b0) begin bad++; $display("FAIL wt_ready2 got=%h exp=0", upd_ready_o); end
    total++; if (mem_add_o !== 32'h1008) begin bad++; $display("FAIL wt_addr_hold got=%h exp=1008", mem_add_o); end
    mem_gnt_i = 1;
    #1;
    total++; if (upd_ready_o !== 1'b1) begin bad++; $display("FAIL wt_ready_gnt got=%h exp=1", upd_ready_o); end
    tick();
    mem_gnt_i = 0; upd_valid_i = 0;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL wt_done got=%h exp=0", mem_req_o); end
`endif
    total++; if (slot_max_o !== 16'h3C00) begin bad++; $display("FAIL wt_max got=%h exp=3c00", slot_max_o); end
    total++; if (slot_den_o !== 32'hAAAA_5555) begin bad++; $display("FAIL wt_den got=%h exp=aaaa5555", slot_den_o); end
  endtask

  task automatic do_update(input logic [15:0] a,
                           input logic [15:0] m,
                           input logic [31:0] d);
    bit ok = 0;
    upd_valid_i = 1; upd_addr_i = a; upd_op_i = 0;
    upd_max_i = m; upd_den_i = d;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk_i);
      mem_gnt_i = mem_req_o;
      #1;
      if (upd_ready_o) ok = 1;
      tick();
      mem_gnt_i = 0;
    end
    upd_valid_i = 0;
    total++; if (!ok) begin bad++; $display("FAIL upd_timeout slot=%h got=0 exp=1", a); end
  endtask

  task automatic test_evict();
    do_update(16'd3, 16'h4003, 32'h30);
    do_update(16'd7, 16'h4007, 32'h70);
    do_update(16'd2, 16'h4002, 32'h20);
    do_update(16'd1, 16'h4001, 32'h10);
    rd_addr_i = 9;
    req_valid_i = 1; req_addr_i = 9; req_op_i = 1;
    #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL ev_ready got=%h exp=1", req_ready_o); end
    tick();
    req_valid_i = 0;
`ifdef SFM_SLOT_CACHE_WRITEBACK_EN
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL ev_wr_req got=%h exp=1", mem_req_o); end
    total++; if (mem_wen_o !== 1'b0) begin bad++; $display("FAIL ev_wr_wen got=%h exp=0", mem_wen_o); end
    total++; if (mem_add_o !== 32'h1018) begin bad++; $display("FAIL ev_wr_addr got=%h exp=1018", mem_add_o); end
    total++; if (mem_data_o !== 64'h0000_4003_0000_0030) begin bad++; $display("FAIL ev_wr_data got=%h exp=0000400300000030", mem_data_o); end
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0;
`endif
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL ev_rd_req got=%h exp=1", mem_req_o); end
    total++; if (mem_wen_o !== 1'b1) begin bad++; $display("FAIL ev_rd_wen got=%h exp=1", mem_wen_o); end
    total++; if (mem_add_o !== 32'h1048) begin bad++; $display("FAIL ev_rd_addr got=%h exp=1048", mem_add_o); end
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0;
    mem_r_valid_i = 1; mem_r_data_i = 64'h0000_5000_0000_0099;
    tick();
    mem_r_valid_i = 0;
    total++; if (slot_valid_o !== 1'b1) begin bad++; $display("FAIL ev_valid got=%h exp=1", slot_valid_o); end
    total++; if (slot_max_o !== 16'h5000) begin bad++; $display("FAIL ev_max got=%h exp=5000", slot_max_o); end
    total++; if (slot_den_o !== 32'h99) begin bad++; $display("FAIL ev_den got=%h exp=99", slot_den_o); end
    rd_addr_i = 3;
    #1;
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL ev_victim_gone got=%h exp=0", slot_valid_o); end
    rd_addr_i = 7;
    #1;
    total++; if (slot_max_o !== 16'h4007) begin bad++; $display("FAIL ev_keep_max got=%h exp=4007", slot_max_o); end
  endtask

  task automatic test_free();
    rd_addr_i = 2;
    upd_valid_i = 1; upd_addr_i = 2; upd_op_i = 1;
    #1;
    total++; if (upd_ready_o !== 1'b1) begin bad++; $display("FAIL free_ready got=%h exp=1", upd_ready_o); end
    tick();
    upd_valid_i = 0;
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL free_valid got=%h exp=0", slot_valid_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL free_mem got=%h exp=0", mem_req_o); end
  endtask

  task automatic test_clear_fetch();
    req_valid_i = 1; req_addr_i = 5; req_op_i = 1;
    tick();
    req_valid_i = 0;
    total++; if (mem_add_o !== 32'h1028) begin bad++; $display("FAIL clr_addr got=%h exp=1028", mem_add_o); end
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0;
    clear_i = 1;
    tick();
    clear_i = 0;
    mem_r_valid_i = 1; mem_r_data_i = 64'h0000_7777_0000_0001;
    tick();
    mem_r_valid_i = 0;
    rd_addr_i = 5;
    #1;
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL clr_late got=%h exp=0", slot_valid_o); end
    rd_addr_i = 9;
    #1;
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL clr_flush9 got=%h exp=0", slot_valid_o); end
    rd_addr_i = 7;
    #1;
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL clr_flush7 got=%h exp=0", slot_valid_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL clr_idle got=%h exp=1", req_ready_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL clr_mem got=%h exp=0", mem_req_o); end
  endtask

  task automatic test_collide();
    upd_valid_i = 1; upd_addr_i = 16'h20; upd_op_i = 0;
    upd_max_i = 16'h1111; upd_den_i = 32'h2222;
    req_valid_i = 1; req_addr_i = 16'h21; req_op_i = 1;
    #1;
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL col_req0 got=%h exp=0", req_ready_o); end
    total++; if (upd_ready_o !== 1'b0) begin bad++; $display("FAIL col_upd0 got=%h exp=0", upd_ready_o); end
    tick();
    total++; if (mem_wen_o !== 1'b0) begin bad++; $display("FAIL col_wen got=%h exp=0", mem_wen_o); end
    total++; if (mem_add_o !== 32'h1100) begin bad++; $display("FAIL col_addr got=%h exp=1100", mem_add_o); end
    total++; if (mem_data_o !== 64'h0000_1111_0000_2222) begin bad++; $display("FAIL col_data got=%h exp=0000111100002222", mem_data_o); end
    mem_gnt_i = 1;
    #1;
    total++; if (upd_ready_o !== 1'b1) begin bad++; $display("FAIL col_upd_gnt got=%h exp=1", upd_ready_o); end
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL col_req_gnt got=%h exp=0", req_ready_o); end
    tick();
    mem_gnt_i = 0; upd_valid_i = 0;
    #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL col_req1 got=%h exp=1", req_ready_o); end
    tick();
    req_valid_i = 0;
    total++; if (mem_wen_o !== 1'b1) begin bad++; $display("FAIL col_rd_wen got=%h exp=1", mem_wen_o); end
    total++; if (mem_add_o !== 32'h1108) begin bad++; $display("FAIL col_rd_addr got=%h exp=1108", mem_add_o); end
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0;
    mem_r_valid_i = 1; mem_r_data_i = 64'h0000_0123_0000_0456;
    tick();
    mem_r_valid_i = 0;
    rd_addr_i = 16'h21;
    #1;
    total++; if (slot_max_o !== 16'h0123) begin bad++; $display("FAIL col_max got=%h exp=0123", slot_max_o); end
    rd_addr_i = 16'h20;
    #1;
    total++; if (slot_valid_o !== 1'b0) begin bad++; $display("FAIL col_noalloc got=%h exp=0", slot_valid_o); end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_alloc();
    test_same_cycle();
    test_writethrough();
    test_evict();
    test_free();
    test_clear_fetch();
    test_collide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
